// File: rtl/flexpipe_pkg.sv
// rtl/flexpipe_pkg.sv - flexpipe memory request/response types and DRAM model slot helpers
package flexpipe_pkg;

    localparam int DATA_WIDTH = 256;
    localparam int LEN_W      = 16;
    localparam int ID_W       = 8;
    localparam int EPOCH_W    = 4;
    localparam int BEAT_W     = LEN_W + 1;
    localparam int CNT_W      = 16;

    typedef struct packed {
        logic [LEN_W-1:0]   len;
        logic [ID_W-1:0]    id;
        logic [EPOCH_W-1:0] epoch;
    } mem_req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ID_W-1:0]       id;
        logic [EPOCH_W-1:0]    epoch;
        logic                  last;
        logic                  error;
    } mem_resp_t;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [EPOCH_W-1:0] epoch;
        logic [BEAT_W-1:0]  beats;
        logic               err;
        logic [CNT_W-1:0]   countdown;
    } dram_slot_t;

    // One extra bit keeps len + bw - 1 from overflowing before the divide.
    function automatic logic [BEAT_W-1:0] dram_beats(input logic [LEN_W-1:0] len, input int unsigned bw);
        logic [BEAT_W-1:0] b;
        b = BEAT_W'(bw);
        return ({1'b0, len} + b - BEAT_W'(1)) / b;
    endfunction

endpackage

// File: rtl/dram_model_pipelined_if.sv
// rtl/dram_model_pipelined_if.sv - request/response handshake bundle of the pipelined DRAM model
interface dram_model_pipelined_if;
    import flexpipe_pkg::*;

    mem_req_t  mem_req;
    logic      mem_req_valid;
    logic      mem_req_ready;
    mem_resp_t mem_resp;
    logic      mem_resp_valid;
    logic      mem_resp_ready;

    modport master (
        output mem_req, mem_req_valid, mem_resp_ready,
        input  mem_req_ready, mem_resp, mem_resp_valid
    );

    modport slave (
        input  mem_req, mem_req_valid, mem_resp_ready,
        output mem_req_ready, mem_resp, mem_resp_valid
    );

endinterface

// File: rtl/flexpipe_sync_fifo.sv
// rtl/flexpipe_sync_fifo.sv - synchronous FIFO with registered occupancy and show-ahead read data
module flexpipe_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_valid,
    output logic             push_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    input  logic             pop
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign push_ready = (count < CW'(DEPTH));
    assign pop_valid  = (count != '0);
    assign pop_data   = mem[rd_ptr];
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop && pop_valid;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dram_model_pipelined.sv
// rtl/dram_model_pipelined.sv - pipelined DRAM endpoint: request FIFO, in-order latency ring, burst sequencer
module dram_model_pipelined
    import flexpipe_pkg::*;
#(
    parameter int BW_BYTES_PER_CYCLE = DATA_WIDTH / 8,
    parameter int FIXED_LATENCY      = 120,
    parameter int REQ_DEPTH          = 16,
    parameter int MAX_OUTSTANDING    = 4,
    parameter int MAX_BEATS          = 64,
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dram_model_pipelined_if.slave  bus,
    output logic [OUT_W-1:0]       outstanding,
    output logic                   idle
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    mem_req_t          fifo_data;
    logic              fifo_push_ready;
    logic              fifo_pop_valid;
    logic              issue;
    logic              release_head;
    logic              can_load;
    logic              src_next;
    logic              src_due;
    logic              load;
    logic              beat_last;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  src;
    logic [BEAT_W-1:0] beat_idx;
    logic [BEAT_W-1:0] issue_beats;
    dram_slot_t        slots [MAX_OUTSTANDING];
    dram_slot_t        issue_slot;
    dram_slot_t        src_slot;
    mem_resp_t         resp;
    logic              resp_valid;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign bus.mem_req_ready = fifo_push_ready & rst_n;

    flexpipe_sync_fifo #(
        .WIDTH ($bits(mem_req_t)),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_data  (bus.mem_req),
        .push_valid (bus.mem_req_valid),
        .push_ready (fifo_push_ready),
        .pop_data   (fifo_data),
        .pop_valid  (fifo_pop_valid),
        .pop        (issue)
    );

    assign issue        = fifo_pop_valid && (outstanding < OUT_W'(MAX_OUTSTANDING));
    assign release_head = resp_valid && resp.last && bus.mem_resp_ready;
    assign can_load     = !resp_valid || bus.mem_resp_ready;

    // While the head's last beat sits in the output register, the next beat
    // comes from the following slot so bursts stream back to back.
    assign src_next  = resp_valid && resp.last;
    assign src       = src_next ? next_ptr(head) : head;
    assign src_slot  = slots[src];
    assign src_due   = (src_next ? (outstanding > OUT_W'(1)) : (outstanding != '0))
                       && (src_slot.countdown == '0);
    assign load      = can_load && src_due;
    assign beat_last = (beat_idx == src_slot.beats - BEAT_W'(1));

    always_comb begin
        issue_beats          = dram_beats(fifo_data.len, BW_BYTES_PER_CYCLE);
        issue_slot           = '0;
        issue_slot.id        = fifo_data.id;
        issue_slot.epoch     = fifo_data.epoch;
        issue_slot.beats     = issue_beats;
        issue_slot.err       = (fifo_data.len == '0) || (issue_beats > BEAT_W'(MAX_BEATS));
        issue_slot.countdown = CNT_W'(FIXED_LATENCY);
    end

    // Slot payloads need no reset: occupancy is carried by head/tail/outstanding.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (slots[i].countdown != '0) begin
                slots[i].countdown <= slots[i].countdown - CNT_W'(1);
            end
        end
        if (issue) begin
            slots[tail] <= issue_slot;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head        <= '0;
            tail        <= '0;
            outstanding <= '0;
        end else begin
            if (issue) begin
                tail <= next_ptr(tail);
            end
            if (release_head) begin
                head <= next_ptr(head);
            end
            case ({issue, release_head})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp       <= '0;
            beat_idx   <= '0;
        end else if (load) begin
            resp_valid <= 1'b1;
            resp.id    <= src_slot.id;
            resp.epoch <= src_slot.epoch;
            if (src_slot.err) begin
                resp.data  <= '0;
                resp.error <= 1'b1;
                resp.last  <= 1'b1;
                beat_idx   <= '0;
            end else begin
                resp.data  <= DATA_WIDTH'(beat_idx);
                resp.error <= 1'b0;
                resp.last  <= beat_last;
                beat_idx   <= beat_last ? '0 : beat_idx + BEAT_W'(1);
            end
        end else if (can_load) begin
            resp_valid <= 1'b0;
        end
    end

    assign bus.mem_resp       = resp;
    assign bus.mem_resp_valid = resp_valid;
    assign idle               = !fifo_pop_valid && (outstanding == '0) && !resp_valid;

endmodule

// File: tb/tb_dram_model_pipelined.sv
// tb/tb_dram_model_pipelined.sv - directed and randomized checks of dram_model_pipelined against a burst-list model
module tb_dram_model_pipelined;
    import flexpipe_pkg::*;

    localparam int BW    = 32;
    localparam int LAT   = 10;
    localparam int MAXO  = 4;
    localparam int DEPTH = 16;
    localparam int MAXB  = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] outstanding;
    logic       idle;

    dram_model_pipelined_if bus ();

    dram_model_pipelined #(
        .BW_BYTES_PER_CYCLE (BW),
        .FIXED_LATENCY      (LAT),
        .REQ_DEPTH          (DEPTH),
        .MAX_OUTSTANDING    (MAXO),
        .MAX_BEATS          (MAXB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .outstanding (outstanding),
        .idle        (idle)
    );

    always #5 clk = ~clk;

    int        n_cmp = 0;
    int        n_bad = 0;
    int        max_out = 0;
    mem_resp_t exp_q[$];
    mem_resp_t e;

    // Every accepted request expands into its full expected beat list.
    function automatic void model_accept(input mem_req_t r);
        int        nb;
        mem_resp_t b;
        nb = (int'(r.len) + BW - 1) / BW;
        if (r.len == 0 || nb > MAXB) begin
            b = '0;
            b.id = r.id;
            b.epoch = r.epoch;
            b.last = 1'b1;
            b.error = 1'b1;
            exp_q.push_back(b);
        end else begin
            for (int i = 0; i < nb; i++) begin
                b = '0;
                b.data = DATA_WIDTH'(i);
                b.id = r.id;
                b.epoch = r.epoch;
                b.last = (i == nb - 1);
                exp_q.push_back(b);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                model_accept(bus.mem_req);
            end
            if (bus.mem_resp_valid && bus.mem_resp_ready) begin
                n_cmp++;
                assert (exp_q.size() != 0) else begin
                    n_bad++;
                    $error("FAIL beat_extra: observed beat id=%0h data=%0h, expected no beat", bus.mem_resp.id, bus.mem_resp.data[15:0]);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    assert (bus.mem_resp === e) else begin
                        n_bad++;
                        $error("FAIL beat: observed id=%0h ep=%0h data=%0h last=%0b err=%0b expected id=%0h ep=%0h data=%0h last=%0b err=%0b",
                               bus.mem_resp.id, bus.mem_resp.epoch, bus.mem_resp.data[15:0], bus.mem_resp.last, bus.mem_resp.error,
                               e.id, e.epoch, e.data[15:0], e.last, e.error);
                    end
                end
            end
            if (int'(outstanding) > max_out) max_out = int'(outstanding);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send(input int len, input int id, input int ep);
        bus.mem_req.len   = LEN_W'(len);
        bus.mem_req.id    = ID_W'(id);
        bus.mem_req.epoch = EPOCH_W'(ep);
        bus.mem_req_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (bus.mem_req_ready) begin
                step();
                bus.mem_req_valid = 1'b0;
                return;
            end
            step();
        end
        chk("send_ready", bus.mem_req_ready, 1);
        bus.mem_req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int k;
        k = 0;
        while (!(idle && exp_q.size() == 0) && k < bound) begin
            step();
            k++;
        end
        chk(tag, idle && exp_q.size() == 0, 1);
    endtask

    initial begin
        int       accepted;
        int       sent;
        logic     acc;
        logic     seen;
        mem_req_t r;

        rst_n = 1'b0;
        bus.mem_req = '0;
        bus.mem_req_valid = 1'b0;
        bus.mem_resp_ready = 1'b1;

        // Reset values.
        repeat (3) step();
        chk("rst_req_ready", bus.mem_req_ready, 0);
        chk("rst_resp_valid", bus.mem_resp_valid, 0);
        chk("rst_resp_zero", bus.mem_resp == '0, 1);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", bus.mem_req_ready, 1);
        chk("post_rst_outstanding", outstanding, 0);
        chk("post_rst_idle", idle, 1);

        // Single two-beat burst and its latency.
        send(64, 5, 2);
        repeat (11) step();
        chk("single_early", bus.mem_resp_valid, 0);
        step();
        chk("single_b0_valid", bus.mem_resp_valid, 1);
        chk("single_b0_data", bus.mem_resp.data[15:0], 0);
        chk("single_b0_id", bus.mem_resp.id, 5);
        chk("single_b0_epoch", bus.mem_resp.epoch, 2);
        chk("single_b0_last", bus.mem_resp.last, 0);
        step();
        chk("single_b1_data", bus.mem_resp.data[15:0], 1);
        chk("single_b1_last", bus.mem_resp.last, 1);
        step();
        chk("single_done", bus.mem_resp_valid, 0);
        wait_idle("single_idle", 100);

        // Four back-to-back single-beat requests.
        max_out = 0;
        for (int i = 0; i < 4; i++) send(32, i, 0);
        repeat (8) step();
        chk("pipe_early", bus.mem_resp_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("pipe_valid", bus.mem_resp_valid, 1);
            chk("pipe_id", bus.mem_resp.id, i);
            chk("pipe_last", bus.mem_resp.last, 1);
        end
        wait_idle("pipe_idle", 100);
        chk("pipe_peak_outstanding", max_out, 4);

        // Backpressure on beat 1 of a three-beat burst.
        send(96, 9, 1);
        repeat (13) step();
        bus.mem_resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", bus.mem_resp_valid, 1);
            chk("bp_data", bus.mem_resp.data[15:0], 1);
        end
        bus.mem_resp_ready = 1'b1;
        wait_idle("bp_idle", 100);

        // Fill FIFO and ring with responses blocked.
        bus.mem_resp_ready = 1'b0;
        accepted = 0;
        for (int c = 0; c < 40; c++) begin
            bus.mem_req.len = 16'd32;
            bus.mem_req.id = ID_W'(32 + accepted);
            bus.mem_req.epoch = 4'd5;
            bus.mem_req_valid = 1'b1;
            if (bus.mem_req_ready) accepted++;
            step();
        end
        bus.mem_req_valid = 1'b0;
        chk("full_accepted", accepted, 20);
        chk("full_outstanding", outstanding, 4);
        chk("full_ready_low", bus.mem_req_ready, 0);
        bus.mem_resp_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            seen = bus.mem_req_ready;
        end
        chk("full_ready_returns", seen, 1);
        wait_idle("full_idle", 500);

        // Error lengths and the legal boundary.
        send(0, 7, 3);
        send(2049, 8, 1);
        send(2048, 10, 0);
        send(1, 11, 2);
        wait_idle("err_idle", 300);

        // Reset in the middle of a four-beat burst.
        send(128, 12, 0);
        repeat (13) step();
        rst_n = 1'b0;
        exp_q.delete();
        step();
        chk("midrst_valid", bus.mem_resp_valid, 0);
        chk("midrst_outstanding", outstanding, 0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.mem_resp_valid) seen = 1'b1;
        end
        chk("midrst_no_beats", seen, 0);
        chk("midrst_idle", idle, 1);
        send(64, 13, 1);
        repeat (11) step();
        chk("midrst_fresh_early", bus.mem_resp_valid, 0);
        step();
        chk("midrst_fresh_valid", bus.mem_resp_valid, 1);
        chk("midrst_fresh_id", bus.mem_resp.id, 13);
        wait_idle("midrst_idle2", 100);

        // Randomized traffic with random response backpressure.
        max_out = 0;
        sent = 0;
        for (int c = 0; c < 8000 && sent < 150; c++) begin
            bus.mem_resp_ready = ($urandom_range(0, 3) != 0);
            if (!bus.mem_req_valid && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 9))
                    0:       r.len = 16'd0;
                    1:       r.len = LEN_W'($urandom_range(2049, 2100));
                    2:       r.len = LEN_W'($urandom_range(2017, 2048));
                    default: r.len = LEN_W'($urandom_range(1, 160));
                endcase
                r.id = ID_W'($urandom);
                r.epoch = EPOCH_W'($urandom);
                bus.mem_req = r;
                bus.mem_req_valid = 1'b1;
            end
            acc = bus.mem_req_valid && bus.mem_req_ready;
            step();
            if (acc) begin
                bus.mem_req_valid = 1'b0;
                sent++;
            end
        end
        bus.mem_req_valid = 1'b0;
        bus.mem_resp_ready = 1'b1;
        chk("rand_sent", sent, 150);
        wait_idle("rand_idle", 5000);
        chk("rand_outstanding_bound", max_out <= MAXO, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dram_model_pipelined.md
# dram_model_pipelined

Parametrised, pipelined successor to the single-outstanding DRAM model, used as the memory endpoint in Verilator simulation of the flexpipe fabric. It queues `mem_req_t` requests, keeps up to `MAX_OUTSTANDING` of them in flight with a fixed access latency, and returns a multi-beat `mem_resp_t` burst per request: `ceil(len/BW_BYTES_PER_CYCLE)` beats, in order, under response backpressure. Illegal lengths are answered with an error beat.

## Interface
- `BW_BYTES_PER_CYCLE`, default `DATA_WIDTH/8`: bytes carried per response beat.
- `FIXED_LATENCY`, default 120: cycles from issue until the request becomes response-eligible; must be ≥1.
- `REQ_DEPTH`, default 16: request FIFO depth, a power of two.
- `MAX_OUTSTANDING`, default 4: number of issued, uncompleted requests; ≥1.
- `MAX_BEATS`, default 64: largest legal burst length in beats.
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `mem_req`, in, `mem_req_t`: request; fields `len`, `id`, `epoch` are used.
- `mem_req_valid`, in, 1: request valid.
- `mem_req_ready`, out, 1: FIFO has space.
- `mem_resp`, out, `mem_resp_t`: response beat (`data`, `id`, `epoch`, `last`, `error`).
- `mem_resp_valid`, out, 1: beat valid.
- `mem_resp_ready`, in, 1: consumer accepts the beat.
- `outstanding`, out, `$clog2(MAX_OUTSTANDING+1)`: number of occupied in-flight slots.
- `idle`, out, 1: FIFO empty, no slots occupied, `mem_resp_valid` low.

## Operation
- **Accept.** A request is pushed into the FIFO on `mem_req_valid && mem_req_ready`.
  - `mem_req_ready = (fifo_count < REQ_DEPTH)`, from registered state only. It never depends on a same-cycle pop.
- **Issue.** Each cycle, if the FIFO is non-empty and `outstanding < MAX_OUTSTANDING`, pop one request into the tail slot of an in-order ring.
  - The slot stores `id`, `epoch`, `beats`, `err`, and a countdown loaded with `FIXED_LATENCY`.
  - Every occupied slot's countdown decrements each cycle and saturates at 0.
- **Beat and error rules.**
  - `beats = ceil(len/BW_BYTES_PER_CYCLE)`, computed with `len` width + 1 bits.
  - `err = (len == 0) || (beats > MAX_BEATS)`.
- **Respond.** The head slot is emitted once its countdown is 0.
  - Normal burst: beats `0..beats-1`. Each beat carries `data` = zero-extended beat index, echoes the slot's `id`/`epoch`, has `error=0`, and has `last=1` on the final beat only.
  - Error slot: exactly one beat with `data=0`, `error=1`, `last=1`.
  - The head slot is released, and `outstanding` decrements, on the handshake of its last beat.
- **Backpressure.** While `mem_resp_valid && !mem_resp_ready`, `mem_resp` holds stable and the beat index holds. Countdowns keep running and issue continues while slots are free.
- **Ordering.** Responses are always returned in acceptance order.
- **Simultaneous events.** Issue and release in the same cycle leave `outstanding` unchanged. Push and pop in the same cycle leave `fifo_count` unchanged.
- **Wrap-around.** FIFO and ring pointers wrap modulo their depths.
- **Reset.** Synchronous reset drops all queued and in-flight requests, including mid-burst. No further beats are produced for them.
  - Reset values: `mem_resp_valid=0`, `mem_resp='0`, `mem_req_ready=0` during reset and 1 after it, `outstanding=0`, `idle=1` after reset.

## Timing
- Unloaded latency: for a request accepted at edge T, beat 0 becomes valid after edge T+FIXED_LATENCY+2.
- With `mem_resp_ready=1`, subsequent beats follow at one per cycle.
- Consecutive due requests stream with no bubble between the last beat of one and beat 0 of the next.
- Issue rate: at most one request per cycle.
- The response datapath is registered; `mem_resp_valid` and `mem_resp` come straight from flops.

## Structure
- `flexpipe_pkg` already provides `mem_req_t`, `mem_resp_t` and `DATA_WIDTH`.
  - Add a slot typedef `dram_slot_t` (`id`, `epoch`, `beats`, `err`, `countdown`).
  - Add the function `dram_beats(len, bw)`.
- Natural sub-module: `flexpipe_sync_fifo` (parametrised width/depth, synchronous active-low reset) for the request queue.
- The slot ring and the beat sequencer stay in this module.

## Test plan
All scenarios use `BW_BYTES_PER_CYCLE=32`, `FIXED_LATENCY=10`, `MAX_OUTSTANDING=4`, `REQ_DEPTH=16` unless stated.
- **Single burst.** One request, `len=64`, `id=5`, `epoch=2`, accepted at edge 0 → beats valid after edges 12 and 13 with `data` 0 and 1, `id=5`, `epoch=2`; `last` on the second beat only.
- **Pipelined issue.** Four back-to-back requests, `len=32` each, ids 0–3 → single beats after edges 12, 13, 14, 15 in id order; `outstanding` peaks at 4.
- **Backpressure.** `len=96`, `mem_resp_ready` low for 5 cycles while beat 1 is presented → beat 1 stays stable throughout; the sequence is 0, 1, 2 with no loss or duplication.
- **Full.** `mem_resp_ready=0`, requests offered every cycle → exactly 20 accepted (16 in the FIFO + 4 in flight), then `mem_req_ready` stays low until a last-beat handshake frees a slot.
- **Errors.** Requests with `len=0` and with `len=2049` (65 beats) → one beat each with `error=1`, `last=1`, `data=0`, ids echoed.
- **Reset mid-operation.** Assert `rst_n=0` for 1 cycle mid-burst of `len=128` → `mem_resp_valid=0` on the next edge; no beats follow; `idle=1`; a new request afterwards completes with fresh latency.
